// File: rtl/mux_varredura_n.sv
`default_nettype none
// ============================================================================
// Module  : mux_varredura_n
// Purpose : Registered N-channel, W-bit mux with manual select or automatic
//           scan (fixed dwell per channel) and a wrap pulse per full scan.
// Rev     : 1.0 - initial release
// ============================================================================
module mux_varredura_n #(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int SW  = 2,
    parameter int DIV = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N*W-1:0]    D,
    input  logic [SW-1:0]     SEL,
    input  logic              modo,
    input  logic              pausa,
    output logic [W-1:0]      OUT,
    output logic [SW-1:0]     canal,
    output logic              fim_ciclo
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [SW:0]   c_n_chan   = (SW+1)'(N);
    localparam logic [SW-1:0] c_last_ch  = SW'(N - 1);
    localparam logic [CW-1:0] c_last_cnt = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [SW-1:0] w_canal_next;
    logic [W-1:0]  w_data_sel;
    logic          w_zero_out;
    logic          w_wrap;

    always_comb begin
        w_canal_next = canal;
        w_cnt_next   = '0;
        w_zero_out   = 1'b0;
        w_wrap       = 1'b0;
        if (!modo) begin
            // Out-of-range select holds the channel but blanks the output
            if ({1'b0, SEL} < c_n_chan) begin
                w_canal_next = SEL;
            end else begin
                w_zero_out = 1'b1;
            end
        end else if (pausa) begin
            w_cnt_next = r_cnt;
        end else if (r_cnt == c_last_cnt) begin
            w_cnt_next = '0;
            if (canal == c_last_ch) begin
                w_canal_next = '0;
                w_wrap       = 1'b1;
            end else begin
                w_canal_next = canal + SW'(1);
            end
        end else begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (w_canal_next == SW'(i)) begin
                w_data_sel = D[i*W +: W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            canal     <= '0;
            OUT       <= '0;
            fim_ciclo <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            canal     <= w_canal_next;
            OUT       <= w_zero_out ? '0 : w_data_sel;
            fim_ciclo <= w_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_varredura_n.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_varredura_n
// Purpose : Self-checking bench for mux_varredura_n (N=4, W=4, SW=2, DIV=3).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_mux_varredura_n;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int SW  = 2;
    localparam int DIV = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N*W-1:0] D     = {4'hD, 4'hC, 4'hB, 4'hA};
    logic [SW-1:0]  SEL   = '0;
    logic           modo  = 1'b0;
    logic           pausa = 1'b0;
    logic [W-1:0]   OUT;
    logic [SW-1:0]  canal;
    logic           fim_ciclo;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_canal = 0;
    int          m_cnt   = 0;
    logic [W-1:0] m_out  = '0;
    logic        m_fim   = 1'b0;

    mux_varredura_n #(.N(N), .W(W), .SW(SW), .DIV(DIV)) dut (
        .clock     (clock),
        .reset     (reset),
        .D         (D),
        .SEL       (SEL),
        .modo      (modo),
        .pausa     (pausa),
        .OUT       (OUT),
        .canal     (canal),
        .fim_ciclo (fim_ciclo)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] chan(input int i);
        return D[i*W +: W];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: dwell of DIV edges per channel, wrap modulo N
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_canal = 0; m_cnt = 0; m_out = '0; m_fim = 1'b0;
        end else begin
            m_fim = 1'b0;
            if (!modo) begin
                m_cnt = 0;
                if (int'(SEL) < N) begin
                    m_canal = int'(SEL);
                    m_out   = chan(m_canal);
                end else begin
                    m_out = '0;
                end
            end else if (pausa) begin
                m_out = chan(m_canal);
            end else begin
                m_cnt++;
                if (m_cnt == DIV) begin
                    m_cnt   = 0;
                    m_canal = (m_canal + 1) % N;
                    m_fim   = (m_canal == 0);
                end
                m_out = chan(m_canal);
            end
        end
    end

    always @(negedge clock) begin
        chk("model_out",   32'(OUT),       32'(m_out));
        chk("model_canal", 32'(canal),     32'(m_canal));
        chk("model_fim",   32'(fim_ciclo), 32'(m_fim));
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic lit(input string tag, input logic [W-1:0] eo, input int ec, input logic ef);
        chk({tag, "_out"},   32'(OUT),       32'(eo));
        chk({tag, "_canal"}, 32'(canal),     32'(ec));
        chk({tag, "_fim"},   32'(fim_ciclo), 32'(ef));
    endtask

    int           seq_c [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
    logic [W-1:0] seq_o [13] = '{4'hA,4'hA,4'hA,4'hB,4'hB,4'hB,4'hC,4'hC,4'hC,4'hD,4'hD,4'hD,4'hA};

    initial begin
        step();
        lit("reset", 4'h0, 0, 1'b0);
        step();
        reset = 1'b0;

        // Manual selection
        SEL = 2'd2;
        step();
        lit("man_sel2", 4'hC, 2, 1'b0);
        SEL = 2'd1;
        step();
        lit("man_sel1", 4'hB, 1, 1'b0);
        D[1*W +: W] = 4'h5;
        step();
        lit("man_live", 4'h5, 1, 1'b0);
        D[1*W +: W] = 4'hB;

        // Async reset between edges, no clock edge involved
        #1;
        reset = 1'b1;
        #1;
        lit("async_rst", 4'h0, 0, 1'b0);
        reset = 1'b0;

        // Scan from canal 0
        SEL = 2'd0;
        step();
        modo = 1'b1;
        lit("scan_0", seq_o[0], seq_c[0], 1'b0);
        for (int k = 1; k < 13; k++) begin
            step();
            lit($sformatf("scan_%0d", k), seq_o[k], seq_c[k], (k == 12));
        end

        // Reach canal=1, cnt=2 then pause
        repeat (5) step();
        lit("pre_pause", 4'hB, 1, 1'b0);
        pausa = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            lit($sformatf("pause_%0d", k), 4'hB, 1, 1'b0);
        end
        pausa = 1'b0;
        step();
        lit("unpause", 4'hC, 2, 1'b0);

        // Scan -> manual
        modo = 1'b0;
        SEL  = 2'd3;
        step();
        lit("to_manual", 4'hD, 3, 1'b0);

        // Reset mid-scan, then full dwell restart from canal 0
        modo = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        #1;
        lit("mid_rst", 4'h0, 0, 1'b0);
        step();
        reset = 1'b0;
        step();
        step();
        lit("rst_dwell2", 4'hA, 0, 1'b0);
        step();
        lit("rst_dwell3", 4'hB, 1, 1'b0);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
